// File: rtl/snes_poller.sv
// snes_poller: polls two SNES pads over a shared latch/clock bus at a fixed
// frame rate and publishes active-high 12-bit button words.
//   clk, reset_n          : system clock, asynchronous active-low reset
//   enable                : periodic polling on; dropping it lets the current frame finish
//   pad1_data, pad2_data  : asynchronous serial data from the pads (0 = pressed)
//   pad_latch, pad_clk    : shared latch (idle low) and serial clock (idle high)
//   p1data, p2data        : button words, bit0 = first serial bit (B) .. bit11 = R
//   valid                 : 1-cycle pulse when p1data/p2data update
//   busy                  : high while a frame is latching or shifting
module snes_poller #(
    parameter int unsigned HALF_CYC    = 144,
    parameter int unsigned POLL_PERIOD = 400000,
    parameter int unsigned NBITS       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pad1_data,
    input  logic        pad2_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] p1data,
    output logic [11:0] p2data,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned DW = 12;
    localparam int unsigned CW = $clog2(2 * HALF_CYC);
    localparam int unsigned TW = $clog2(POLL_PERIOD);
    localparam int unsigned BW = $clog2(NBITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LATCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    s1_q, s2_q;
    logic [DW-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
    logic [DW-1:0] p1_q, p1_d, p2_q, p2_d;
    logic          latch_q, latch_d, pclk_q, pclk_d;
    logic          valid_q, valid_d, busy_q, busy_d;
    logic          sample;

    // Two-flop synchronizers; idle value 1 means "not pressed"
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
        end else begin
            s1_q <= {s1_q[0], pad1_data};
            s2_q <= {s2_q[0], pad2_data};
        end
    end

    // Frame-rate timer, parked at 0 while polling is disabled
    always_comb begin
        timer_d = timer_q;
        if (!enable) begin
            timer_d = '0;
        end else if (timer_q == TW'(POLL_PERIOD - 1)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Next-state, sampling and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        sample  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A timer wrap during a frame is ignored: only a zero seen here starts one
                if (enable && timer_q == '0) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh1_d   = '0;
                    sh2_d   = '0;
                end
            end
            S_LATCH: begin
                if (cnt_q == CW'(2 * HALF_CYC - 1)) begin
                    sample  = 1'b1;
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = BW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                // Bit k is taken at the end of pulse k, after the pad has
                // shifted on that pulse's rising edge and the synchronizer settled
                if (cnt_q == CW'(2 * HALF_CYC - 1)) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (bit_q == BW'(NBITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inverted store; bits past the word width are dropped
        if (sample) begin
            for (int i = 0; i < int'(DW); i++) begin
                if (bit_q == BW'(i)) begin
                    sh1_d[i] = ~s1_q[1];
                    sh2_d[i] = ~s2_q[1];
                end
            end
        end

        // Publish both words together as DONE is entered
        if (state_q != S_DONE && state_d == S_DONE) begin
            p1_d = sh1_d;
            p2_d = sh2_d;
        end

        latch_d = (state_d == S_LATCH);
        pclk_d  = !(state_d == S_SHIFT && cnt_d < CW'(HALF_CYC));
        busy_d  = (state_d == S_LATCH) || (state_d == S_SHIFT);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            timer_q <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign pad_latch = latch_q;
    assign pad_clk   = pclk_q;
    assign p1data    = p1_q;
    assign p2data    = p2_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_snes_poller.sv
// Directed bench for snes_poller with behavioural pads (load on latch,
// shift on pad_clk rise, active-low data).
module tb_snes_poller;

    localparam int unsigned HC = 4;
    localparam int unsigned PP = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        pad1_data, pad2_data;
    logic        pad_latch, pad_clk;
    logic [11:0] p1data, p2data;
    logic        valid, busy;

    logic [15:0] w1 = '0, w2 = '0;
    logic [15:0] sr1 = '1, sr2 = '1;

    int vectors = 0;
    int miscompares = 0;

    snes_poller #(.HALF_CYC(HC), .POLL_PERIOD(PP), .NBITS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .pad1_data (pad1_data),
        .pad2_data (pad2_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .p1data    (p1data),
        .p2data    (p2data),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pad models: parallel load while latched, shift on pad_clk rise
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) begin
            sr1 <= ~w1;
            sr2 <= ~w2;
        end else begin
            sr1 <= {1'b1, sr1[15:1]};
            sr2 <= {1'b1, sr2[15:1]};
        end
    end
    assign pad1_data = sr1[0];
    assign pad2_data = sr2[0];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe cycles 1..140 of a frame whose first latch cycle was just sampled
    task automatic run_frame(output int vidx, output int vcnt, output int falls,
                             output int lows, output int lhi, output logic b127,
                             output logic b128, output logic [11:0] c1,
                             output logic [11:0] c2);
        logic pc_prev;
        pc_prev = pad_clk;
        vidx = -1; vcnt = 0; falls = 0; lows = 0; lhi = 0;
        b127 = 1'bx; b128 = 1'bx; c1 = '0; c2 = '0;
        for (int i = 1; i <= 140; i++) begin
            tick;
            if (!pad_clk) begin
                lows++;
                if (pc_prev) falls++;
            end
            pc_prev = pad_clk;
            if (pad_latch) lhi++;
            if (valid) begin
                vcnt++;
                if (vidx < 0) begin
                    vidx = i;
                    c1 = p1data;
                    c2 = p2data;
                end
            end
            if (i == 127) b127 = busy;
            if (i == 128) b128 = busy;
        end
    endtask

    // Cycles until the next latch rise, -1 if none within maxc
    task automatic wait_latch_rise(input int maxc, output int n);
        logic prev;
        int   i;
        prev = pad_latch;
        n = -1;
        i = 0;
        while (n < 0 && i < maxc) begin
            tick;
            i++;
            if (pad_latch && !prev) n = i;
            prev = pad_latch;
        end
    endtask

    initial begin
        int          vidx, vcnt, falls, lows, lhi, n, seen;
        logic        b127, b128;
        logic [11:0] c1, c2;

        // Reset values
        w1 = {4'h0, 12'b000011100000};
        w2 = {4'h0, 12'b110100110010};
        repeat (3) tick;
        chk("reset_latch", 32'(pad_latch), 32'd0);
        chk("reset_pad_clk", 32'(pad_clk), 32'd1);
        chk("reset_p1", 32'(p1data), 32'd0);
        chk("reset_p2", 32'(p2data), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Release with enable high: first frame starts on the next edge
        enable = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        chk("f1_latch_first", 32'(pad_latch), 32'd1);
        chk("f1_busy_first", 32'(busy), 32'd1);
        run_frame(vidx, vcnt, falls, lows, lhi, b127, b128, c1, c2);
        chk("f1_latch_width", 32'(lhi + 1), 32'd8);
        chk("f1_clk_pulses", 32'(falls), 32'd15);
        chk("f1_clk_low_cycles", 32'(lows), 32'd60);
        chk("f1_valid_cycle", 32'(vidx), 32'd128);
        chk("f1_valid_count", 32'(vcnt), 32'd1);
        chk("f1_busy_last_shift", 32'(b127), 32'd1);
        chk("f1_busy_done", 32'(b128), 32'd0);
        chk("f1_p1", 32'(c1), 32'(12'b000011100000));
        chk("f1_p2", 32'(c2), 32'(12'b110100110010));
        chk("f1_p1_hold", 32'(p1data), 32'(12'b000011100000));

        // Frame 2: extra bits 12..15 pressed must not leak into the words
        w1 = {4'hF, 12'h123};
        w2 = {4'hF, 12'hFFF};
        wait_latch_rise(100, n);
        chk("f2_period", 32'(140 + n), 32'd200);
        run_frame(vidx, vcnt, falls, lows, lhi, b127, b128, c1, c2);
        chk("f2_valid_cycle", 32'(vidx), 32'd128);
        chk("f2_p1_extra_bits", 32'(c1), 32'h123);
        chk("f2_p2_extra_bits", 32'(c2), 32'hFFF);

        // Frame 3: enable dropped mid-shift, frame still completes
        w1 = {4'h0, 12'h801};
        w2 = {4'h0, 12'h000};
        wait_latch_rise(100, n);
        chk("f3_period", 32'(140 + n), 32'd200);
        repeat (40) tick;
        enable = 1'b0;
        seen = -1;
        for (int i = 41; i <= 140; i++) begin
            tick;
            if (valid && seen < 0) begin
                seen = i;
                c1 = p1data;
                c2 = p2data;
            end
        end
        chk("f3_valid_cycle", 32'(seen), 32'd128);
        chk("f3_p1", 32'(c1), 32'h801);
        chk("f3_p2", 32'(c2), 32'h000);
        wait_latch_rise(500, n);
        chk("disabled_no_latch", 32'(n), 32'hFFFF_FFFF);

        // Re-enable: frame starts on the next edge
        w1 = {4'h0, 12'h5A5};
        w2 = {4'h0, 12'h0F0};
        enable = 1'b1;
        tick;
        chk("reenable_latch", 32'(pad_latch), 32'd1);

        // Reset pulse mid-shift: lines idle at once, outputs cleared
        repeat (40) tick;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_latch", 32'(pad_latch), 32'd0);
        chk("midreset_pad_clk", 32'(pad_clk), 32'd1);
        chk("midreset_p1", 32'(p1data), 32'd0);
        chk("midreset_p2", 32'(p2data), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_valid", 32'(valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        chk("postreset_latch", 32'(pad_latch), 32'd1);
        run_frame(vidx, vcnt, falls, lows, lhi, b127, b128, c1, c2);
        chk("postreset_valid_cycle", 32'(vidx), 32'd128);
        chk("postreset_valid_count", 32'(vcnt), 32'd1);
        chk("postreset_p1", 32'(c1), 32'h5A5);
        chk("postreset_p2", 32'(c2), 32'h0F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
